// File: rtl/simon_round_fsm.sv
// Simon game controller: grows a random pattern sequence, replays it on show_tick,
// then checks player entries. Optional input timeout is enabled by SIMON_TIMEOUT_EN.
module simon_round_fsm #(
  parameter int unsigned SW_W           = 8,
  parameter int unsigned SEQ_DEPTH      = 8,
  parameter int unsigned NUM_LIVES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [SW_W-1:0]                    random_num,
  input  logic [SW_W-1:0]                    swt,
  input  logic                               start_game,
  input  logic                               enter_move,
  input  logic                               show_tick,
  output logic                               show_valid,
  output logic [SW_W-1:0]                    show_value,
  output logic                               input_phase,
  output logic [$clog2(SEQ_DEPTH+1)-1:0]     round,
  output logic [NUM_LIVES-1:0]               lives_led,
  output logic                               miss,
  output logic                               game_won,
  output logic                               game_over
);

  localparam int unsigned RW = $clog2(SEQ_DEPTH + 1);
  localparam int unsigned IW = $clog2(SEQ_DEPTH);
  localparam int unsigned LW = $clog2(NUM_LIVES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW, S_INPUT, S_PENALTY, S_WON, S_LOST
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     round_q, round_d;
  logic [LW-1:0]     lives_q, lives_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW_W-1:0]   seq_q [SEQ_DEPTH];

  logic              seq_we;
  logic [IW-1:0]     seq_waddr;
  logic              last_c;
  logic              match_c;
  logic              fail_c;
  logic              timeout_c;

  logic              show_valid_q, show_valid_d;
  logic [SW_W-1:0]   show_value_q, show_value_d;
  logic              input_phase_q, input_phase_d;
  logic [NUM_LIVES-1:0] lives_led_q, lives_led_d;
  logic              miss_q, miss_d;
  logic              game_won_q, game_won_d;
  logic              game_over_q, game_over_d;

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Counter restarts on INPUT entry and on every submitted move
  always_comb begin
    tcnt_d = '0;
    if (state_q == S_INPUT && !enter_move) tcnt_d = TW'(tcnt_q + TW'(1));
  end

  assign timeout_c = (state_q == S_INPUT) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) tcnt_q <= '0;
    else       tcnt_q <= tcnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  assign last_c  = (idx_q == IW'(round_q - RW'(1)));
  assign match_c = (swt == seq_q[idx_q]);
  assign fail_c  = (state_q == S_INPUT) && ((enter_move && !match_c) || (!enter_move && timeout_c));

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    lives_d   = lives_q;
    idx_d     = idx_q;
    seq_we    = 1'b0;
    seq_waddr = '0;

    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        if (start_game) begin
          seq_we    = 1'b1;
          seq_waddr = '0;
          round_d   = RW'(1);
          lives_d   = LW'(NUM_LIVES);
          idx_d     = '0;
          state_d   = S_SHOW;
        end
      end
      S_SHOW: begin
        if (show_tick) begin
          if (last_c) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d = IW'(idx_q + IW'(1));
          end
        end
      end
      S_INPUT: begin
        if (fail_c) begin
          lives_d = LW'(lives_q - LW'(1));
          state_d = (lives_q == LW'(1)) ? S_LOST : S_PENALTY;
        end else if (enter_move) begin
          if (!last_c) begin
            idx_d = IW'(idx_q + IW'(1));
          end else if (round_q == RW'(SEQ_DEPTH)) begin
            state_d = S_WON;
          end else begin
            // round < SEQ_DEPTH here, so it addresses the next free slot
            seq_we    = 1'b1;
            seq_waddr = IW'(round_q);
            round_d   = RW'(round_q + RW'(1));
            idx_d     = '0;
            state_d   = S_SHOW;
          end
        end
      end
      S_PENALTY: begin
        if (start_game) begin
          idx_d   = '0;
          state_d = S_SHOW;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they align with the state
    show_valid_d  = (state_d == S_SHOW);
    input_phase_d = (state_d == S_INPUT);
    miss_d        = (state_d == S_PENALTY);
    game_won_d    = (state_d == S_WON);
    game_over_d   = (state_d == S_LOST);
    show_value_d  = '0;
    if (state_d == S_SHOW) begin
      show_value_d = (seq_we && seq_waddr == idx_d) ? random_num : seq_q[idx_d];
    end
    lives_led_d = '0;
    for (int i = 0; i < int'(NUM_LIVES); i++) begin
      lives_led_d[i] = (lives_d > LW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      lives_q       <= '0;
      idx_q         <= '0;
      show_valid_q  <= 1'b0;
      show_value_q  <= '0;
      input_phase_q <= 1'b0;
      lives_led_q   <= '0;
      miss_q        <= 1'b0;
      game_won_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      lives_q       <= lives_d;
      idx_q         <= idx_d;
      show_valid_q  <= show_valid_d;
      show_value_q  <= show_value_d;
      input_phase_q <= input_phase_d;
      lives_led_q   <= lives_led_d;
      miss_q        <= miss_d;
      game_won_q    <= game_won_d;
      game_over_q   <= game_over_d;
    end
  end

  // Sequence memory is never cleared; only written slots are ever read
  always_ff @(posedge clock) begin
    if (!reset && seq_we) seq_q[seq_waddr] <= random_num;
  end

  assign show_valid  = show_valid_q;
  assign show_value  = show_value_q;
  assign input_phase = input_phase_q;
  assign round       = round_q;
  assign lives_led   = lives_led_q;
  assign miss        = miss_q;
  assign game_won    = game_won_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_simon_round_fsm.sv
// Randomised self-checking bench for simon_round_fsm against a queue-based game model.
module tb_simon_round_fsm;

  localparam int SW_W = 8;
  localparam int SEQ_DEPTH = 4;
  localparam int NUM_LIVES = 3;
  localparam int TIMEOUT_CYCLES = 16;

  localparam int P_IDLE = 0, P_SHOW = 1, P_INPUT = 2, P_PEN = 3, P_WON = 4, P_LOST = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [SW_W-1:0] random_num = '0;
  logic [SW_W-1:0] swt = '0;
  logic start_game = 1'b0, enter_move = 1'b0, show_tick = 1'b0;
  logic show_valid, input_phase, miss, game_won, game_over;
  logic [SW_W-1:0] show_value;
  logic [2:0] round;
  logic [NUM_LIVES-1:0] lives_led;

  simon_round_fsm #(
    .SW_W(SW_W), .SEQ_DEPTH(SEQ_DEPTH), .NUM_LIVES(NUM_LIVES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .random_num(random_num), .swt(swt),
    .start_game(start_game), .enter_move(enter_move), .show_tick(show_tick),
    .show_valid(show_valid), .show_value(show_value), .input_phase(input_phase),
    .round(round), .lives_led(lives_led), .miss(miss), .game_won(game_won),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase, sequence queue, round, lives, replay/entry position
  int m_phase = P_IDLE;
  logic [SW_W-1:0] m_seq[$];
  int m_round = 0, m_lives = 0, m_idx = 0, m_tcnt = 0;
  bit m_valid = 0;

  task automatic m_lose();
    m_lives--;
    m_phase = (m_lives == 0) ? P_LOST : P_PEN;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_phase = P_IDLE; m_round = 0; m_lives = 0; m_idx = 0; m_tcnt = 0;
      m_seq.delete();
      m_valid = 1;
    end else begin
      case (m_phase)
        P_IDLE, P_WON, P_LOST:
          if (start_game) begin
            m_seq.delete(); m_seq.push_back(random_num);
            m_round = 1; m_lives = NUM_LIVES; m_idx = 0; m_phase = P_SHOW;
          end
        P_SHOW:
          if (show_tick) begin
            if (m_idx == m_round - 1) begin m_idx = 0; m_tcnt = 0; m_phase = P_INPUT; end
            else m_idx++;
          end
        P_INPUT:
          if (enter_move) begin
            m_tcnt = 0;
            if (swt != m_seq[m_idx]) m_lose();
            else if (m_idx < m_round - 1) m_idx++;
            else if (m_round == SEQ_DEPTH) m_phase = P_WON;
            else begin
              m_seq.push_back(random_num); m_round++; m_idx = 0; m_phase = P_SHOW;
            end
          end else begin
`ifdef SIMON_TIMEOUT_EN
            if (m_tcnt == TIMEOUT_CYCLES - 1) m_lose();
            else m_tcnt++;
`endif
          end
        P_PEN:
          if (start_game) begin m_idx = 0; m_phase = P_SHOW; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (m_valid) begin
      chk("show_valid", 32'(show_valid), 32'(m_phase == P_SHOW));
      chk("show_value", 32'(show_value), (m_phase == P_SHOW) ? 32'(m_seq[m_idx]) : 32'd0);
      chk("input_phase", 32'(input_phase), 32'(m_phase == P_INPUT));
      chk("round", 32'(round), 32'(m_round));
      chk("lives_led", 32'(lives_led), 32'((1 << m_lives) - 1));
      chk("miss", 32'(miss), 32'(m_phase == P_PEN));
      chk("game_won", 32'(game_won), 32'(m_phase == P_WON));
      chk("game_over", 32'(game_over), 32'(m_phase == P_LOST));
    end
  end

  task automatic step(input logic st, input logic en, input logic tk,
                      input logic [SW_W-1:0] sw, input logic [SW_W-1:0] rn, input logic rs);
    start_game = st; enter_move = en; show_tick = tk; swt = sw; random_num = rn; reset = rs;
    @(negedge clock);
    start_game = 0; enter_move = 0; show_tick = 0; reset = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 8'(($urandom)), 0);
  endtask

  task automatic tick_through();
    int b = 0;
    while (m_phase == P_SHOW && b < 40) begin
      if ($urandom_range(0, 2) == 0) idle();
      else step(0, 0, 1, 8'(($urandom)), 8'(($urandom)), 0);
      b++;
    end
    if (m_phase == P_SHOW) chk("show_timeout", 32'(m_phase), 32'(P_INPUT));
  endtask

  task automatic play_round();
    int n = m_round;
    for (int i = 0; i < n; i++) begin
      if (m_phase != P_INPUT) break;
      step(0, 1, 0, m_seq[m_idx], 8'(($urandom)), 0);
    end
  endtask

  task automatic wrong_move();
    logic [SW_W-1:0] flip = 8'(($urandom_range(1, 255)));
    step(0, 1, 0, m_seq[m_idx] ^ flip, 8'(($urandom)), 0);
  endtask

  initial begin
    @(negedge clock);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_round", 32'(round), 32'd0);
    chk("reset_lives", 32'(lives_led), 32'd0);

    // First game: A5 seed, win through all rounds
    step(1, 0, 0, 0, 8'hA5, 0);
    chk("start_value", 32'(show_value), 32'hA5);
    chk("start_lives", 32'(lives_led), 32'b111);
    chk("start_round", 32'(round), 32'd1);
    tick_through();
    chk("first_input", 32'(input_phase), 32'd1);
    for (int r = 0; r < SEQ_DEPTH && m_phase == P_INPUT; r++) begin
      play_round();
      tick_through();
    end
    chk("won", 32'(game_won), 32'd1);
    chk("won_round", 32'(round), 32'd4);

    // Life loss in round 2, then replay and run out of lives
    step(1, 0, 0, 0, 8'(($urandom)), 0);
    tick_through();
    play_round();
    tick_through();
    wrong_move();
    chk("miss", 32'(miss), 32'd1);
    chk("miss_lives", 32'(lives_led), 32'b011);
    step(1, 0, 0, 0, 0, 0);
    tick_through();
    wrong_move();
    step(1, 0, 0, 0, 0, 0);
    tick_through();
    wrong_move();
    chk("over", 32'(game_over), 32'd1);
    chk("over_lives", 32'(lives_led), 32'd0);
    step(1, 0, 0, 0, 8'h3C, 0);
    chk("restart_round", 32'(round), 32'd1);
    chk("restart_lives", 32'(lives_led), 32'b111);
    chk("restart_value", 32'(show_value), 32'h3C);

    // Reset mid-INPUT at round 3 beats a simultaneous enter_move
    tick_through(); play_round(); tick_through(); play_round(); tick_through();
    chk("r3_round", 32'(round), 32'd3);
    step(0, 1, 0, m_seq[m_idx], 0, 1);
    chk("rst_input", 32'(input_phase), 32'd0);
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_lives", 32'(lives_led), 32'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_enter_ignored", 32'(input_phase), 32'd0);

`ifdef SIMON_TIMEOUT_EN
    step(1, 0, 0, 0, 8'h5A, 0);
    tick_through();
    for (int i = 0; i < TIMEOUT_CYCLES; i++) idle();
    chk("to_miss", 32'(miss), 32'd1);
    chk("to_lives", 32'(lives_led), 32'b011);
    step(1, 0, 0, 0, 0, 0);
    tick_through();
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) idle();
    step(0, 1, 0, 8'h5A, 8'h11, 0);
    chk("to_enter_miss", 32'(miss), 32'd0);
    chk("to_enter_round", 32'(round), 32'd2);
`endif

    // Random play: mostly correct entries, occasional errors, stray pulses and resets
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom_range(0, 99);
      logic st = ($urandom_range(0, 9) == 0);
      logic tk = ($urandom_range(0, 2) == 0);
      logic en = ($urandom_range(0, 2) == 0);
      logic [SW_W-1:0] sw = 8'(($urandom));
      if (m_phase == P_INPUT && $urandom_range(0, 4) != 0) sw = m_seq[m_idx];
      step(st, en, tk, sw, 8'(($urandom)), r == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
